modexp_sequencer: RTL and testbench



---
 rtl/montgomery_pkg.sv | 18 +
 rtl/modexp_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_modexp_sequencer.sv | 383 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/montgomery_pkg.sv
// Shared Montgomery-datapath definitions: modexp sequencer FSM states and
// default operand geometry used by the sequencer and the multiplier core.
package montgomery_pkg;

  localparam int unsigned MONT_W = 32;
  localparam int unsigned MONT_S = 8;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    SQ_ISSUE,
    SQ_WAIT,
    MUL_ISSUE,
    MUL_WAIT,
    FINISH
  } mx_state_e;

endpackage

// File: rtl/modexp_sequencer.sv
// Square-and-multiply modexp controller driving one external Montgomery multiplier.
// Optional MODEXP_CONST_TIME_EN: square and multiply on every exponent bit, fixed latency.
module modexp_sequencer
  import montgomery_pkg::*;
#(
  parameter int unsigned W        = MONT_W,
  parameter int unsigned S        = MONT_S,
  parameter int unsigned EXP_BITS = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [W-1:0]        base_mont [S],
  input  logic [W-1:0]        one_mont  [S],
  input  logic [EXP_BITS-1:0] exp,
  input  logic [W-1:0]        m         [S],
  input  logic [W-1:0]        m_prime,
  output logic                busy,
  output logic                done,
  output logic [W-1:0]        result    [S],
  output logic                mm_start,
  output logic [W-1:0]        mm_a      [S],
  output logic [W-1:0]        mm_b      [S],
  output logic [W-1:0]        mm_m      [S],
  output logic [W-1:0]        mm_m_prime,
  input  logic [W-1:0]        mm_result [S],
  input  logic                mm_done
);

  localparam int unsigned     IDX_W   = (EXP_BITS > 1) ? $clog2(EXP_BITS) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(EXP_BITS - 1);

  mx_state_e           state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [EXP_BITS-1:0] exp_q, exp_d;
  logic [W-1:0]        acc_q [S], acc_d [S];
  logic [W-1:0]        base_q [S], base_d [S];
  logic [W-1:0]        one_q [S], one_d [S];
  logic [W-1:0]        mm_m_q [S], mm_m_d [S];
  logic [W-1:0]        mm_m_prime_q, mm_m_prime_d;
  logic [W-1:0]        mm_a_q [S], mm_a_d [S];
  logic [W-1:0]        mm_b_q [S], mm_b_d [S];
  logic [W-1:0]        result_q [S], result_d [S];
  logic                mm_start_q, mm_start_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    exp_d        = exp_q;
    acc_d        = acc_q;
    base_d       = base_q;
    one_d        = one_q;
    mm_m_d       = mm_m_q;
    mm_m_prime_d = mm_m_prime_q;
    mm_a_d       = mm_a_q;
    mm_b_d       = mm_b_q;
    result_d     = result_q;
    mm_start_d   = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          base_d       = base_mont;
          one_d        = one_mont;
          exp_d        = exp;
          mm_m_d       = m;
          mm_m_prime_d = m_prime;
          busy_d       = 1'b1;
          idx_d        = IDX_TOP;
`ifdef MODEXP_CONST_TIME_EN
          acc_d        = one_mont;
          state_d      = SQ_ISSUE;
`else
          state_d      = SCAN;
`endif
        end
      end

      // Leading zeros cost one cycle each; the first set bit seeds acc with base.
      SCAN: begin
        if (exp_q[idx_q]) begin
          acc_d = base_q;
          if (idx_q == '0) begin
            state_d = FINISH;
          end else begin
            idx_d   = idx_q - 1'b1;
            state_d = SQ_ISSUE;
          end
        end else if (idx_q == '0) begin
          acc_d   = one_q;
          state_d = FINISH;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end

      SQ_ISSUE: begin
        mm_a_d     = acc_q;
        mm_b_d     = acc_q;
        mm_start_d = 1'b1;
        state_d    = SQ_WAIT;
      end

      SQ_WAIT: begin
        if (mm_done) begin
          acc_d = mm_result;
`ifdef MODEXP_CONST_TIME_EN
          state_d = MUL_ISSUE;
`else
          if (exp_q[idx_q]) begin
            state_d = MUL_ISSUE;
          end else if (idx_q == '0) begin
            state_d = FINISH;
          end else begin
            idx_d   = idx_q - 1'b1;
            state_d = SQ_ISSUE;
          end
`endif
        end
      end

      MUL_ISSUE: begin
        mm_a_d     = acc_q;
        mm_b_d     = base_q;
        mm_start_d = 1'b1;
        state_d    = MUL_WAIT;
      end

      // Constant-time mode always multiplies but keeps the product only for set bits.
      MUL_WAIT: begin
        if (mm_done) begin
`ifdef MODEXP_CONST_TIME_EN
          if (exp_q[idx_q]) acc_d = mm_result;
`else
          acc_d = mm_result;
`endif
          if (idx_q == '0) begin
            state_d = FINISH;
          end else begin
            idx_d   = idx_q - 1'b1;
            state_d = SQ_ISSUE;
          end
        end
      end

      FINISH: begin
        result_d = acc_q;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      exp_q        <= '0;
      acc_q        <= '{default: '0};
      base_q       <= '{default: '0};
      one_q        <= '{default: '0};
      mm_m_q       <= '{default: '0};
      mm_m_prime_q <= '0;
      mm_a_q       <= '{default: '0};
      mm_b_q       <= '{default: '0};
      result_q     <= '{default: '0};
      mm_start_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      exp_q        <= exp_d;
      acc_q        <= acc_d;
      base_q       <= base_d;
      one_q        <= one_d;
      mm_m_q       <= mm_m_d;
      mm_m_prime_q <= mm_m_prime_d;
      mm_a_q       <= mm_a_d;
      mm_b_q       <= mm_b_d;
      result_q     <= result_d;
      mm_start_q   <= mm_start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign result     = result_q;
  assign mm_start   = mm_start_q;
  assign mm_a       = mm_a_q;
  assign mm_b       = mm_b_q;
  assign mm_m       = mm_m_q;
  assign mm_m_prime = mm_m_prime_q;

endmodule

// File: tb/tb_modexp_sequencer.sv
// Directed bench for modexp_sequencer with a behavioural REDC multiplier responder
// and an independent plain-domain modexp reference (W=32, S=2, EXP_BITS=8).
module tb_modexp_sequencer;

  localparam int unsigned W        = 32;
  localparam int unsigned S        = 2;
  localparam int unsigned EXP_BITS = 8;
  localparam int          LAT      = 3;
  localparam logic [63:0] MOD      = 64'h0000_0001_F123_4567;

  logic                clk;
  logic                rst;
  logic                start;
  logic [W-1:0]        base_arr [S];
  logic [W-1:0]        one_arr  [S];
  logic [EXP_BITS-1:0] exp_in;
  logic [W-1:0]        m_arr    [S];
  logic [W-1:0]        m_prime;
  logic                busy;
  logic                done;
  logic [W-1:0]        result_arr [S];
  logic                mm_start;
  logic [W-1:0]        mm_a_arr [S];
  logic [W-1:0]        mm_b_arr [S];
  logic [W-1:0]        mm_m_arr [S];
  logic [W-1:0]        mm_m_prime;
  logic [W-1:0]        mm_res_arr [S];
  logic                mm_done;

  int   checks = 0;
  int   errors = 0;
  int   call_cnt = 0;
  int   done_cnt = 0;
  logic [15:0] kind_bits = '0;

  modexp_sequencer #(.W(W), .S(S), .EXP_BITS(EXP_BITS)) dut (
    .clk(clk), .rst(rst), .start(start),
    .base_mont(base_arr), .one_mont(one_arr), .exp(exp_in),
    .m(m_arr), .m_prime(m_prime),
    .busy(busy), .done(done), .result(result_arr),
    .mm_start(mm_start), .mm_a(mm_a_arr), .mm_b(mm_b_arr),
    .mm_m(mm_m_arr), .mm_m_prime(mm_m_prime),
    .mm_result(mm_res_arr), .mm_done(mm_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [63:0] cat2(input logic [31:0] v [2]);
    return {v[1], v[0]};
  endfunction

  // Bit-serial REDC: a*b*2^-64 mod MOD, for a,b < MOD.
  function automatic logic [63:0] mont(input logic [63:0] a, input logic [63:0] b);
    logic [66:0] t;
    t = '0;
    for (int i = 0; i < 64; i++) begin
      if (a[i]) t = t + {3'b0, b};
      if (t[0]) t = t + {3'b0, MOD};
      t = t >> 1;
    end
    if (t >= {3'b0, MOD}) t = t - {3'b0, MOD};
    return t[63:0];
  endfunction

  function automatic logic [63:0] mulmod(input logic [63:0] x, input logic [63:0] y);
    logic [127:0] p;
    p = ({64'b0, x} * {64'b0, y}) % {64'b0, MOD};
    return p[63:0];
  endfunction

  function automatic logic [63:0] to_mont(input logic [63:0] x);
    logic [127:0] p;
    p = {x, 64'b0} % {64'b0, MOD};
    return p[63:0];
  endfunction

  function automatic logic [63:0] golden(input logic [EXP_BITS-1:0] e, input logic [63:0] b);
    logic [63:0] r;
    logic [63:0] bb;
    r  = 64'd1;
    bb = b;
    for (int i = 0; i < EXP_BITS; i++) begin
      if (e[i]) r = mulmod(r, bb);
      bb = mulmod(bb, bb);
    end
    return to_mont(r);
  endfunction

  function automatic int exp_calls(input logic [EXP_BITS-1:0] e);
`ifdef MODEXP_CONST_TIME_EN
    return 2 * EXP_BITS;
`else
    int msb;
    int pop;
    msb = -1;
    pop = 0;
    for (int i = 0; i < EXP_BITS; i++) begin
      if (e[i]) begin
        msb = i;
        pop++;
      end
    end
    return (msb < 0) ? 0 : msb + pop - 1;
`endif
  endfunction

  // Multiplier responder: answers each mm_start after LAT cycles, keeps running through resets.
  initial begin
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] r;
    mm_done       = 1'b0;
    mm_res_arr[0] = '0;
    mm_res_arr[1] = '0;
    forever begin
      @(posedge clk); #1;
      if (mm_start === 1'b1) begin
        a = cat2(mm_a_arr);
        b = cat2(mm_b_arr);
        call_cnt++;
        kind_bits = {kind_bits[14:0], (a == b)};
        r = mont(a, b);
        repeat (LAT - 1) begin @(posedge clk); #1; end
        mm_res_arr[0] = r[31:0];
        mm_res_arr[1] = r[63:32];
        mm_done = 1'b1;
        @(posedge clk); #1;
        mm_done = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (done === 1'b1) done_cnt++;
    end
  end

  task automatic set_base(input logic [63:0] b);
    logic [63:0] bm;
    bm = to_mont(b);
    base_arr[0] = bm[31:0];
    base_arr[1] = bm[63:32];
  endtask

  // Starts one operation and waits for done; optionally re-pulses start with another base mid-run.
  task automatic run_op(input logic [EXP_BITS-1:0] e, input logic [63:0] b,
                        input bit interfere, output int lat);
    bit poked;
    poked    = 1'b0;
    call_cnt = 0;
    done_cnt = 0;
    kind_bits = '0;
    set_base(b);
    exp_in = e;
    start  = 1'b1;
    @(posedge clk); #2;
    start  = 1'b0;
    lat    = 1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_accept: got %b want 1", busy);
    end
    while (done !== 1'b1 && lat < 3000) begin
      if (interfere && !poked && call_cnt == 1) begin
        set_base(64'h0000_0000_0BAD_F00D);
        exp_in = ~e;
        start  = 1'b1;
        poked  = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #2;
      lat++;
    end
    start = 1'b0;
    if (lat >= 3000) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles", lat);
    end
  endtask

  task automatic check_result(input string name, input logic [63:0] want);
    checks++;
    if (cat2(result_arr) !== want) begin
      errors++;
      $display("FAIL %s: result got %h want %h", name, cat2(result_arr), want);
    end
  endtask

  task automatic check_calls(input string name, input int want);
    checks++;
    if (call_cnt != want) begin
      errors++;
      $display("FAIL %s: mm_start pulses got %0d want %0d", name, call_cnt, want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if ({busy, done, mm_start} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl: busy/done/mm_start got %b want 000", {busy, done, mm_start});
    end
    checks++;
    if ({cat2(result_arr), cat2(mm_a_arr), cat2(mm_b_arr), cat2(mm_m_arr), mm_m_prime} !== '0) begin
      errors++;
      $display("FAIL reset_data: result %h mm_a %h mm_b %h mm_m %h mm_m_prime %h want all 0",
               cat2(result_arr), cat2(mm_a_arr), cat2(mm_b_arr), cat2(mm_m_arr), mm_m_prime);
    end
    rst = 1'b0;
    @(posedge clk); #2;
  endtask

  task automatic test_exp_zero();
    int lat;
    run_op('0, 64'h0000_0001_2345_6789, 1'b0, lat);
    check_result("exp_zero", to_mont(64'd1));
    check_calls("exp_zero_calls", exp_calls('0));
`ifndef MODEXP_CONST_TIME_EN
    checks++;
    if (lat != EXP_BITS + 2) begin
      errors++;
      $display("FAIL exp_zero_latency: got %0d want %0d", lat, EXP_BITS + 2);
    end
`endif
    @(posedge clk); #2;
    checks++;
    if (busy !== 1'b0 || done_cnt != 1) begin
      errors++;
      $display("FAIL exp_zero_end: busy %b done pulses %0d want 0 and 1", busy, done_cnt);
    end
  endtask

  task automatic test_exp_one();
    int lat;
    run_op(8'h01, 64'h0000_0000_DEAD_BEEF, 1'b0, lat);
    check_result("exp_one", to_mont(64'h0000_0000_DEAD_BEEF));
    check_calls("exp_one_calls", exp_calls(8'h01));
  endtask

  task automatic test_exp_d();
    int lat;
    run_op(8'h0D, 64'h0000_0001_2345_6789, 1'b0, lat);
    check_result("exp_d", golden(8'h0D, 64'h0000_0001_2345_6789));
    check_calls("exp_d_calls", exp_calls(8'h0D));
`ifndef MODEXP_CONST_TIME_EN
    checks++;
    if (kind_bits[4:0] !== 5'b10110) begin
      errors++;
      $display("FAIL exp_d_order: sq/mul pattern got %b want 10110", kind_bits[4:0]);
    end
`endif
    checks++;
    if (cat2(mm_m_arr) !== MOD || mm_m_prime !== m_prime) begin
      errors++;
      $display("FAIL latched_modulus: mm_m %h mm_m_prime %h want %h %h",
               cat2(mm_m_arr), mm_m_prime, MOD, m_prime);
    end
  endtask

  task automatic test_start_ignored();
    int lat;
    run_op(8'h0D, 64'h0000_0000_DEAD_BEEF, 1'b1, lat);
    repeat (4) @(posedge clk);
    #2;
    check_result("start_ignored", golden(8'h0D, 64'h0000_0000_DEAD_BEEF));
    check_calls("start_ignored_calls", exp_calls(8'h0D));
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL start_ignored_done: done pulses got %0d want 1", done_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    run_op(8'h0B, 64'h0000_0000_1357_9BDF, 1'b0, lat);
    check_result("b2b_first", golden(8'h0B, 64'h0000_0000_1357_9BDF));
    run_op(8'hA5, 64'h0000_0001_0000_0003, 1'b0, lat);
    check_result("b2b_second", golden(8'hA5, 64'h0000_0001_0000_0003));
    check_calls("b2b_second_calls", exp_calls(8'hA5));
  endtask

  task automatic test_reset_mid();
    int n;
    int bad;
    call_cnt = 0;
    done_cnt = 0;
    set_base(64'h0000_0001_2345_6789);
    exp_in = 8'h0D;
    start  = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    n = 0;
    while (call_cnt < 2 && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (busy !== 1'b0 || done !== 1'b0 || mm_start !== 1'b0) bad++;
      @(posedge clk); #2;
    end
    checks++;
    if (bad != 0 || done_cnt != 0 || call_cnt != 2) begin
      errors++;
      $display("FAIL reset_mid_ctrl: bad cycles %0d done pulses %0d calls %0d want 0 0 2",
               bad, done_cnt, call_cnt);
    end
    checks++;
    if ({cat2(result_arr), cat2(mm_a_arr), cat2(mm_b_arr), cat2(mm_m_arr), mm_m_prime} !== '0) begin
      errors++;
      $display("FAIL reset_mid_data: result %h mm_a %h mm_m %h want 0",
               cat2(result_arr), cat2(mm_a_arr), cat2(mm_m_arr));
    end
  endtask

`ifdef MODEXP_CONST_TIME_EN
  task automatic test_const_time();
    int lat0;
    int lat1;
    int calls0;
    run_op('0, 64'h0000_0000_DEAD_BEEF, 1'b0, lat0);
    calls0 = call_cnt;
    check_result("ct_zero", to_mont(64'd1));
    run_op('1, 64'h0000_0000_DEAD_BEEF, 1'b0, lat1);
    check_result("ct_ones", golden('1, 64'h0000_0000_DEAD_BEEF));
    checks++;
    if (calls0 != 2 * EXP_BITS || call_cnt != 2 * EXP_BITS) begin
      errors++;
      $display("FAIL ct_calls: got %0d and %0d want %0d", calls0, call_cnt, 2 * EXP_BITS);
    end
    checks++;
    if (lat0 != lat1) begin
      errors++;
      $display("FAIL ct_latency: exp=0 took %0d, exp=all-ones took %0d", lat0, lat1);
    end
  endtask
`endif

  initial begin
    logic [31:0] inv;
    rst    = 1'b1;
    start  = 1'b0;
    exp_in = '0;
    m_arr[0] = MOD[31:0];
    m_arr[1] = MOD[63:32];
    inv = 32'd1;
    for (int i = 0; i < 5; i++) inv = inv * (32'd2 - MOD[31:0] * inv);
    m_prime = -inv;
    one_arr[0] = to_mont(64'd1) >> 0;
    one_arr[1] = 32'(to_mont(64'd1) >> 32);
    set_base(64'd5);

    test_reset();
    test_exp_zero();
    test_exp_one();
    test_exp_d();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
`ifdef MODEXP_CONST_TIME_EN
    test_const_time();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
